// File: rtl/dsdemod1_pkg.sv
// Shared definitions for the sinc^2 delta-sigma demodulator: bit mapping and CIC width.
package dsdemod1_pkg;

  function automatic int cic_w(input int m);
    return 2*m + 2;
  endfunction

  // 1 -> +1, 0 -> -1, as a 2-bit two's-complement code for sign extension
  function automatic logic [1:0] pm1(input logic b);
    return b ? 2'b01 : 2'b11;
  endfunction

endpackage

// File: rtl/dsdemod1_cic_integ.sv
// Wrapping CIC integrator; sum is the value the accumulator takes at the next edge.
module cic_integ #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         clr,
  input  logic [W-1:0] add,
  output logic [W-1:0] sum
);

  logic [W-1:0] acc;

  assign sum = acc + add;

  always_ff @(posedge clk) begin
    if (!clr) acc <= '0;
    else      acc <= sum;
  end

endmodule

// File: rtl/dsdemod1.sv
// Second-order CIC decimator: 1-bit stream in, signed n-bit sample every 2^m clocks.
module dsdemod1
  import dsdemod1_pkg::*;
#(
  parameter int n = 4,
  parameter int m = 4
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         in,
  output logic [n-1:0] out,
  output logic         str
);

  localparam int W    = cic_w(m);
  localparam int SH   = 2*m + 1 - n;
  localparam int MAXV = 2**(n-1) - 1;
  localparam int MINV = -(2**(n-1));
  localparam logic [m-1:0] ONE = 1;

  logic [1:0]   xs;
  logic [W-1:0] x, i1n, i2n, dz, c1z, c1, c2, sh;
  logic [n-1:0] sat;
  logic [m-1:0] cnt;
  logic         warm, dec;

  assign xs = pm1(in);
  assign x  = {{(W-2){xs[1]}}, xs};

  cic_integ #(.W(W)) u_i1 (.clk(clk), .clr(clr), .add(x),   .sum(i1n));
  cic_integ #(.W(W)) u_i2 (.clk(clk), .clr(clr), .add(i1n), .sum(i2n));

  assign dec = &cnt;
  assign c1  = i2n - dz;
  assign c2  = c1 - c1z;
  assign sh  = $signed(c2) >>> SH;

  // Only the all-ones window (+R^2) can exceed the positive rail
  always_comb begin
    sat = sh[n-1:0];
    if ($signed(sh) > MAXV)      sat = MAXV[n-1:0];
    else if ($signed(sh) < MINV) sat = MINV[n-1:0];
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      cnt  <= '0;
      dz   <= '0;
      c1z  <= '0;
      warm <= 1'b0;
      out  <= '0;
      str  <= 1'b0;
    end else begin
      cnt <= cnt + ONE;
      str <= 1'b0;
      if (dec) begin
        dz   <= i2n;
        c1z  <= c1;
        warm <= 1'b1;
        // first window after reset is zero-padded, so it is swallowed
        if (warm) begin
          out <= sat;
          str <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dsdemod1.sv
// Scoreboard bench for dsdemod1: triangular-window reference model vs. DUT strobes.
module tb_dsdemod1;

  localparam int N  = 4;
  localparam int M  = 4;
  localparam int R  = 1 << M;
  localparam int SH = 2*M + 1 - N;

  logic         clk = 1'b0;
  logic         clr = 1'b0;
  logic         in  = 1'b0;
  logic [N-1:0] out;
  logic         str;

  dsdemod1 #(.n(N), .m(M)) dut (.clk(clk), .clr(clr), .in(in), .out(out), .str(str));

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n++;

  typedef struct { int tag; int val; } exp_t;
  exp_t q[$];

  int checks = 0, failures = 0;
  int hist[$];
  int mcnt = 0, mk = 0, rst_tag = -1;
  int sd_acc = 0;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d edge=%0d", nm, act, req, edge_n);
    end
  endtask

  // sinc^2 over the last 2R bits: newest R bits weigh 1..R, the R before weigh R-1..0
  function automatic int sample();
    int c2, s, L, wgt;
    c2 = 0;
    L  = hist.size();
    for (int j = 0; j < 2*R; j++) begin
      wgt = (j < R) ? j + 1 : 2*R - 1 - j;
      if (L - 1 - j >= 0) c2 += wgt * hist[L-1-j];
    end
    s = c2 >>> SH;
    if (s > (1 << (N-1)) - 1) s = (1 << (N-1)) - 1;
    if (s < -(1 << (N-1)))    s = -(1 << (N-1));
    return s;
  endfunction

  task automatic model(input logic c, input logic b, input int tag);
    if (!c) begin
      hist.delete();
      mcnt = 0; mk = 0; rst_tag = tag;
    end else begin
      hist.push_back(b ? 1 : -1);
      if (hist.size() > 2*R) void'(hist.pop_front());
      mcnt++;
      if (mcnt == R) begin
        mcnt = 0;
        mk++;
        if (mk >= 2) q.push_back('{tag, sample()});
      end
    end
  endtask

  task automatic step(input logic c, input logic b);
    @(negedge clk);
    clr = c; in = b;
    model(c, b, edge_n + 1);
  endtask

  // first-order delta-sigma source producing mean v/2^(N-1)
  function automatic logic sd_bit(input int v);
    sd_acc += v + (1 << (N-1));
    if (sd_acc >= (1 << N)) begin
      sd_acc -= (1 << N);
      return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic run_sd(input int v, input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b1, sd_bit(v));
  endtask

  initial begin : monitor
    int a, last_out;
    exp_t e;
    last_out = 0;
    forever begin
      @(posedge clk);
      #1;
      a = $signed(out);
      if (edge_n == rst_tag) begin
        chk("reset_out", a, 0);
        chk("reset_str", int'(str), 0);
        last_out = 0;
      end else if (str) begin
        if (q.size() == 0) chk("str_unexpected", int'(str), 0);
        else begin
          e = q.pop_front();
          chk("strobe_time", edge_n, e.tag);
          chk("sample", a, e.val);
        end
        last_out = a;
      end else begin
        if (q.size() > 0 && q[0].tag <= edge_n) begin
          chk("str_missed", int'(str), 1);
          void'(q.pop_front());
        end
        chk("hold", a, last_out);
      end
    end
  end

  initial begin : stim
    repeat (3) step(1'b0, 1'b0);
    repeat (20*R) step(1'b1, 1'($urandom_range(0, 1)));
    step(1'b0, 1'b0);
    repeat (6*R) step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    repeat (6*R) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 6*R; i++) step(1'b1, (i % 2) == 0);
    step(1'b0, 1'b0);
    sd_acc = 0;
    run_sd(7, 8*R);
    run_sd(-8, 8*R);
    run_sd(0, 8*R);
    run_sd(3, 8*R);
    run_sd(-5, 5*R);
    while (mcnt != 9) step(1'b1, sd_bit(-5));
    step(1'b0, 1'b0);
    run_sd(-5, 6*R);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0);
      repeat (3*R + int'($urandom_range(0, R-1))) step(1'b1, 1'($urandom_range(0, 1)));
    end
    run_sd(7, 3000);
    step(1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("drain", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
